scan_chain_controller: RTL and testbench

- Initiator end of the CSR scan chain: drives `scan_enable`/`scan_in` into the chain head and collects `scan_out` from the chain tail.
- Converts a byte-wide valid/ready host stream into serial scan shifts and returns the displaced chain contents as a byte stream.
- One transaction replaces the whole chain (`CHAIN_LEN` bits) and reads back its prior contents.
- Used for test/debug load and unload of the CSR bank.

---
 rtl/scan_chain_controller_pkg.sv | 22 ++
 rtl/scan_chain_controller_if.sv | 32 +++
 rtl/scan_chain_controller_shifter.sv | 48 ++++
 rtl/scan_chain_controller.sv | 87 ++++++++
 tb/tb_scan_chain_controller.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_chain_controller_pkg.sv
// Shared types and defaults for the CSR scan-chain initiator.
// The state encoding is one-hot so every decoded output is a single flop bit.
package scan_ctrl_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_CHAIN_LEN = 64;

    localparam int IDX_IDLE   = 0;
    localparam int IDX_LOAD   = 1;
    localparam int IDX_SHIFT  = 2;
    localparam int IDX_UNLOAD = 3;
    localparam int IDX_DONE   = 4;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_LOAD   = 5'b00010,
        ST_SHIFT  = 5'b00100,
        ST_UNLOAD = 5'b01000,
        ST_DONE   = 5'b10000
    } state_t;

endpackage

// File: rtl/scan_chain_controller_if.sv
// Host stream, chain pins and status of the scan-chain initiator.
// Handshakes: a byte moves on any rising edge where valid and ready are both 1.
interface scan_chain_controller_if import scan_ctrl_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic             abort;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             scan_enable;
    logic             scan_in;
    logic             scan_out;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    modport master (
        output start, abort, in_data, in_valid, out_ready, scan_out,
        input  in_ready, out_data, out_valid, scan_enable, scan_in, busy, done, dbg_state
    );

    modport slave (
        input  start, abort, in_data, in_valid, out_ready, scan_out,
        output in_ready, out_data, out_valid, scan_enable, scan_in, busy, done, dbg_state
    );

endinterface

// File: rtl/scan_chain_controller_shifter.sv
// Byte-wide parallel/serial converter: drives the chain head from tx[0] and
// captures the chain tail into rx, both LSB-first.
module scan_byte_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic             scan_out,
    output logic             scan_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             last_bit
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [CW-1:0]    r_bit_cnt;
    logic             w_last;

    assign w_last = (r_bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_bit_cnt <= '0;
        end else if (load) begin
            r_tx      <= load_data;
            r_bit_cnt <= '0;
        end else if (shift) begin
            r_tx <= r_tx >> 1;
            r_rx <= {scan_out, r_rx[WIDTH-1:1]};
            // Hold on the final bit so the counter never wraps mid-transaction.
            if (!w_last) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
        end
    end

    assign scan_in  = r_tx[0];
    assign rx_data  = r_rx;
    assign last_bit = w_last;

endmodule

// File: rtl/scan_chain_controller.sv
// Scan-chain initiator: swaps the whole chain for NBYTES host bytes and streams
// the displaced contents back. CHAIN_LEN must be a multiple of WIDTH.
module scan_chain_controller import scan_ctrl_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
    input logic                     clk,
    input logic                     rst,
    scan_chain_controller_if.slave  bus
);

    localparam int NBYTES = CHAIN_LEN / WIDTH;
    localparam int BCW    = $clog2(NBYTES) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [BCW-1:0]   r_byte_cnt;
    logic             w_load;
    logic             w_shift;
    logic             w_last_bit;
    logic             w_out_hs;
    logic             w_last_byte;
    logic [WIDTH-1:0] w_rx;

    assign w_load      = r_state[IDX_LOAD] & bus.in_valid & ~bus.abort;
    assign w_shift     = r_state[IDX_SHIFT];
    assign w_out_hs    = r_state[IDX_UNLOAD] & bus.out_ready & ~bus.abort;
    assign w_last_byte = (r_byte_cnt == BCW'(NBYTES - 1));

    scan_byte_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .shift     (w_shift),
        .load_data (bus.in_data),
        .scan_out  (bus.scan_out),
        .scan_in   (bus.scan_in),
        .rx_data   (w_rx),
        .last_bit  (w_last_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (bus.start)    w_next = ST_LOAD;
                ST_LOAD:   if (bus.in_valid) w_next = ST_SHIFT;
                ST_SHIFT:  if (w_last_bit)   w_next = ST_UNLOAD;
                ST_UNLOAD: if (bus.out_ready) w_next = w_last_byte ? ST_DONE : ST_LOAD;
                ST_DONE:   w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt <= '0;
        end else if (r_state[IDX_IDLE] & bus.start & ~bus.abort) begin
            r_byte_cnt <= '0;
        end else if (w_out_hs) begin
            r_byte_cnt <= r_byte_cnt + BCW'(1);
        end
    end

    // Each flag is one flop of the one-hot state, so scan_enable cannot glitch.
    always_comb begin
        bus.in_ready    = r_state[IDX_LOAD];
        bus.scan_enable = r_state[IDX_SHIFT];
        bus.out_valid   = r_state[IDX_UNLOAD];
        bus.done        = r_state[IDX_DONE];
        bus.busy        = ~r_state[IDX_IDLE];
        bus.out_data    = w_rx;
        bus.dbg_state   = r_state;
    end

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: a 16-bit and a 64-bit chain model, each
// driven by its own controller, with a byte-level scoreboard of chain contents.
module tb_scan_chain_controller;
    import scan_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    scan_chain_controller_if #(.WIDTH(8)) if16 ();
    scan_chain_controller_if #(.WIDTH(8)) if64 ();

    scan_chain_controller #(.WIDTH(8), .CHAIN_LEN(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    scan_chain_controller #(.WIDTH(8), .CHAIN_LEN(64)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    // Chain models: shift in at the head (MSB), tail bit 0 leaves first.
    logic [15:0] chain16 = 16'h3CA5;
    logic [63:0] chain64 = 64'h8877665544332211;
    always @(posedge clk) begin
        if (if16.scan_enable) chain16 <= {if16.scan_in, chain16[15:1]};
        if (if64.scan_enable) chain64 <= {if64.scan_in, chain64[63:1]};
    end
    assign if16.scan_out = chain16[0];
    assign if64.scan_out = chain64[0];

    int cyc = 0, se_cnt64 = 0, done_cnt64 = 0, done_cnt16 = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (if64.scan_enable) se_cnt64 <= se_cnt64 + 1;
        if (if64.done) done_cnt64 <= done_cnt64 + 1;
        if (if16.done) done_cnt16 <= done_cnt16 + 1;
    end

    // Byte-level reference of what each chain holds, in exit order.
    logic [7:0] ref16[2] = '{8'hA5, 8'h3C};
    logic [7:0] ref64[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] wr16[2];
    logic [7:0] wr64[8];
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic test_reset();
        rst = 1'b0;
        if16.start = 0; if16.abort = 0; if16.in_data = 0; if16.in_valid = 0; if16.out_ready = 0;
        if64.start = 0; if64.abort = 0; if64.in_data = 0; if64.in_valid = 0; if64.out_ready = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({if64.busy, if64.scan_enable, if64.in_ready, if64.out_valid, if64.done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags64: got %b expected 00000",
                {if64.busy, if64.scan_enable, if64.in_ready, if64.out_valid, if64.done});
        end
        n_checks++;
        if (if64.out_data !== 8'h00 || if16.out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_data: got %h/%h expected 00/00", if64.out_data, if16.out_data);
        end
        n_checks++;
        if (if64.dbg_state !== ST_IDLE || if16.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got %b busy16=%b expected %b busy16=0",
                if64.dbg_state, if16.busy, ST_IDLE);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic txn16();
        int d0, c0, t;
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin exp_q.push_back(ref16[i]); ref16[i] = wr16[i]; end
        d0 = done_cnt16;
        @(negedge clk); if16.start = 1'b1; c0 = cyc;
        @(negedge clk); if16.start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if16.in_data = wr16[b]; if16.in_valid = 1'b1;
            t = 0; while (!if16.in_ready && t < 20) begin @(negedge clk); t++; end
            n_checks++;
            if (if16.in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready16: got %b expected 1", if16.in_ready); end
            @(negedge clk); if16.in_valid = 1'b0;
            t = 0; while (!if16.out_valid && t < 20) begin @(negedge clk); t++; end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (if16.out_valid !== 1'b1 || if16.out_data !== e) begin
                n_fail++; $display("FAIL read16_byte%0d: got %h (valid %b) expected %h", b, if16.out_data, if16.out_valid, e);
            end
            if16.out_ready = 1'b1; @(negedge clk); if16.out_ready = 1'b0;
        end
        t = 0; while (!if16.done && t < 10) begin @(negedge clk); t++; end
        n_checks++;
        if (cyc - c0 + 1 !== 22) begin n_fail++; $display("FAIL latency16: got %0d expected 22", cyc - c0 + 1); end
        @(negedge clk);
        n_checks++;
        if (done_cnt16 - d0 !== 1 || if16.busy !== 1'b0) begin
            n_fail++; $display("FAIL done16: got pulses=%0d busy=%b expected 1/0", done_cnt16 - d0, if16.busy);
        end
    endtask

    task automatic txn64(input int in_stall, input int out_stall, input bit hold_start);
        int d0, c0, s0, t;
        logic [7:0] e, hold;
        for (int i = 0; i < 8; i++) begin exp_q.push_back(ref64[i]); ref64[i] = wr64[i]; end
        d0 = done_cnt64; s0 = se_cnt64;
        @(negedge clk); if64.start = 1'b1; c0 = cyc;
        @(negedge clk); if64.start = hold_start;
        for (int b = 0; b < 8; b++) begin
            if (b == 0) begin
                for (int k = 0; k < in_stall; k++) begin
                    n_checks++;
                    if (if64.scan_enable !== 1'b0 || if64.in_ready !== 1'b1) begin
                        n_fail++; $display("FAIL in_stall: got se=%b rdy=%b expected 0/1", if64.scan_enable, if64.in_ready);
                    end
                    @(negedge clk);
                end
            end
            if64.in_data = wr64[b]; if64.in_valid = 1'b1;
            t = 0; while (!if64.in_ready && t < 20) begin @(negedge clk); t++; end
            n_checks++;
            if (if64.in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready64: got %b expected 1", if64.in_ready); end
            @(negedge clk); if64.in_valid = 1'b0;
            t = 0; while (!if64.out_valid && t < 20) begin @(negedge clk); t++; end
            if (b == 3) begin
                hold = if64.out_data;
                for (int k = 0; k < out_stall; k++) begin
                    n_checks++;
                    if (if64.out_valid !== 1'b1 || if64.scan_enable !== 1'b0 || if64.out_data !== hold) begin
                        n_fail++; $display("FAIL out_stall: got v=%b se=%b data=%h expected 1/0/%h",
                            if64.out_valid, if64.scan_enable, if64.out_data, hold);
                    end
                    @(negedge clk);
                end
            end
            if (b == 7) if64.start = 1'b0;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (if64.out_valid !== 1'b1 || if64.out_data !== e) begin
                n_fail++; $display("FAIL read64_byte%0d: got %h (valid %b) expected %h", b, if64.out_data, if64.out_valid, e);
            end
            if64.out_ready = 1'b1; @(negedge clk); if64.out_ready = 1'b0;
        end
        t = 0; while (!if64.done && t < 10) begin @(negedge clk); t++; end
        if (in_stall == 0 && out_stall == 0) begin
            n_checks++;
            if (cyc - c0 + 1 !== 82) begin n_fail++; $display("FAIL latency64: got %0d expected 82", cyc - c0 + 1); end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt64 - d0 !== 1 || if64.busy !== 1'b0) begin
            n_fail++; $display("FAIL done64: got pulses=%0d busy=%b expected 1/0", done_cnt64 - d0, if64.busy);
        end
        n_checks++;
        if (se_cnt64 - s0 !== 64) begin n_fail++; $display("FAIL shift_count64: got %0d expected 64", se_cnt64 - s0); end
    endtask

    task automatic test_fifo16();
        wr16 = '{8'h12, 8'h34}; txn16();
        wr16 = '{8'h00, 8'h00}; txn16();
    endtask

    task automatic test_fifo64();
        for (int i = 0; i < 8; i++) wr64[i] = 8'(i + 1);
        txn64(0, 0, 1'b0);
        for (int i = 0; i < 8; i++) wr64[i] = 8'($urandom_range(0, 255));
        txn64(0, 0, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) wr64[i] = 8'($urandom_range(0, 255));
        txn64(5, 7, 1'b0);
    endtask

    task automatic test_abort();
        int d0;
        logic [63:0] c;
        for (int i = 0; i < 8; i++) c[i*8 +: 8] = ref64[i];
        wr64[0] = 8'($urandom_range(0, 255));
        d0 = done_cnt64;
        @(negedge clk); if64.start = 1'b1;
        @(negedge clk); if64.start = 1'b0; if64.in_data = wr64[0]; if64.in_valid = 1'b1;
        @(negedge clk); if64.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); if64.abort = 1'b1;
        n_checks++;
        if (if64.scan_enable !== 1'b1) begin n_fail++; $display("FAIL abort_in_shift: got se=%b expected 1", if64.scan_enable); end
        @(negedge clk); if64.abort = 1'b0;
        n_checks++;
        if ({if64.busy, if64.scan_enable, if64.in_ready, if64.out_valid} !== 4'b0 || if64.dbg_state !== ST_IDLE) begin
            n_fail++; $display("FAIL abort_idle: got %b state=%b expected 0000 state=%b",
                {if64.busy, if64.scan_enable, if64.in_ready, if64.out_valid}, if64.dbg_state, ST_IDLE);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (done_cnt64 !== d0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt64 - d0); end
        // Three edges saw scan_enable high before abort took effect.
        c = {wr64[0][2], wr64[0][1], wr64[0][0], c[63:3]};
        for (int i = 0; i < 8; i++) ref64[i] = c[i*8 +: 8];
        if64.start = 1'b1; if64.abort = 1'b1;
        @(negedge clk); if64.start = 1'b0; if64.abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (if64.busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: got busy=%b expected 0", if64.busy); end
        for (int i = 0; i < 8; i++) wr64[i] = 8'($urandom_range(0, 255));
        txn64(0, 0, 1'b0);
    endtask

    task automatic test_start_held();
        for (int i = 0; i < 8; i++) wr64[i] = 8'($urandom_range(0, 255));
        txn64(0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); if64.start = 1'b1;
        @(negedge clk); if64.start = 1'b0; if64.in_data = 8'h5A; if64.in_valid = 1'b1;
        @(negedge clk); if64.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({if64.busy, if64.scan_enable, if64.in_ready, if64.out_valid, if64.done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mid_flags: got %b expected 00000",
                {if64.busy, if64.scan_enable, if64.in_ready, if64.out_valid, if64.done});
        end
        n_checks++;
        if (if64.out_data !== 8'h00 || if64.dbg_state !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_mid_state: got data=%h state=%b expected 00 state=%b",
                if64.out_data, if64.dbg_state, ST_IDLE);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fifo16();
        test_fifo64();
        test_stall();
        test_abort();
        test_start_held();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
